// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Cycles from the start-bit falling edge to the end of the last stop bit.
    function automatic int frame_cycles(input int clks_per_bit, input int data_w, input int stop_bits);
        return (1 + data_w + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: ticks in the last cycle of every CLKS_PER_BIT-cycle bit
// while run is high, and starts counting from zero each time run rises.
// pre_tick fires one cycle earlier so registered outputs can line up with tick.
module baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Hold at zero while stopped so every run starts a fresh bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = run && (cnt_q == LAST_CNT);
    assign pre_tick = run && (cnt_q == PRE_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Self-timed FIFO reader that serialises each popped byte as a UART frame
// (start bit, DATA_W data bits LSB first, STOP_BITS stop bits) on tx.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout,
    output logic              rd,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam int BW = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              byte_done_q, byte_done_d;
    logic              pop;
    logic              run;
    logic              tick;
    logic              pre_tick;

    assign pop = (state_q == IDLE) && enable && !empty;
    assign run = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    // State register: reset abandons any partial frame and parks the line high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= IDLE_LVL;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            byte_done_q <= byte_done_d;
        end
    end

    // Next-state logic: bit_cnt counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                shift_d   = dout;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: tx is computed from the upcoming state so the registered
    // line changes in the same cycle the FSM enters each phase.
    always_comb begin
        tx_d = IDLE_LVL;
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
        byte_done_d = (state_q == STOP) && (bit_cnt_q == BW'(STOP_BITS - 1)) && pre_tick;
        rd          = pop && reset;
        busy        = (pop && reset) || (state_q != IDLE);
    end

    assign tx        = tx_q;
    assign byte_done = byte_done_q;

endmodule
